// File: rtl/branch_pkg.sv
// Shared types for execute-side branch resolution.
// Prediction entry layout and resolve FSM states.
package branch_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] targ;
    } pred_entry_t;

    typedef enum logic {
        RUN,
        RDIR
    } state_t;

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of fetch predictions awaiting resolution.
// Clear wins over push/pop; push while full is legal only with a pop.
module pred_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  pred_entry_t   i_wdata,
    input  logic          i_pop,
    input  logic          i_clear,
    output pred_entry_t   o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    pred_entry_t   r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/branch_resolve.sv
// Checks execute outcomes against queued fetch predictions and
// issues a one-cycle redirect plus mispredict count on mismatch.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             F_PUSH,
    input  logic [31:0]      F_PC,
    input  logic             F_PRED_TAKEN,
    input  logic [31:0]      F_PRED_TARG,
    output logic             F_READY,
    input  logic             X_RESOLVE,
    input  logic [31:0]      X_PC,
    input  logic             X_TAKEN,
    input  logic [31:0]      X_TARG,
    input  logic             FLUSH,
    output logic             REDIRECT_VALID,
    output logic [31:0]      REDIRECT_PC,
    output logic [CNT_W-1:0] MISPRED_CNT,
    output logic             ORDER_ERR
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic              r_rdir_v;
    logic [31:0]       r_rdir_pc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_oerr;

    pred_entry_t       w_wdata;
    pred_entry_t       w_head;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_run;
    logic              w_res;
    logic              w_pop;
    logic              w_mis;
    logic              w_push;
    logic              w_clear;
    logic              w_oerr;
    logic [31:0]       w_fix_pc;

    assign w_run   = (r_state == RUN);
    assign w_res   = X_RESOLVE && w_run && !FLUSH;
    assign w_pop   = w_res && !w_empty;
    assign w_mis   = w_pop && ((w_head.taken != X_TAKEN) ||
                               (X_TAKEN && (w_head.targ != X_TARG)));
    // A same-edge pop frees a slot, so a full queue may still take a push
    assign w_push  = F_PUSH && w_run && (!w_full || w_pop) &&
                     !FLUSH && !w_mis;
    assign w_clear = FLUSH || w_mis;
    assign w_oerr  = w_res && (w_empty || (X_PC != w_head.pc));
    assign w_fix_pc = X_TAKEN ? X_TARG : X_PC + INSTR_BYTES;

    assign w_wdata = '{pc: F_PC, taken: F_PRED_TAKEN, targ: F_PRED_TARG};

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = RUN;
        case (r_state)
            RUN:     w_state_nx = w_mis ? RDIR : RUN;
            RDIR:    w_state_nx = RUN;
            default: w_state_nx = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_rdir_v  <= 1'b0;
            r_rdir_pc <= '0;
            r_cnt     <= '0;
            r_oerr    <= 1'b0;
        end else begin
            r_rdir_v <= w_mis;
            if (w_mis) begin
                r_rdir_pc <= w_fix_pc;
            end
            if (w_mis && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_oerr) begin
                r_oerr <= 1'b1;
            end
        end
    end

    assign F_READY        = w_run && (w_count < CW'(DEPTH));
    assign REDIRECT_VALID = r_rdir_v;
    assign REDIRECT_PC    = r_rdir_pc;
    assign MISPRED_CNT    = r_cnt;
    assign ORDER_ERR      = r_oerr;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed vector bench for branch_resolve (narrow counter to
// exercise saturation).
module tb_branch_resolve;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int NV    = 29;

    logic             CLK;
    logic             RST_N;
    logic             F_PUSH;
    logic [31:0]      F_PC;
    logic             F_PRED_TAKEN;
    logic [31:0]      F_PRED_TARG;
    logic             F_READY;
    logic             X_RESOLVE;
    logic [31:0]      X_PC;
    logic             X_TAKEN;
    logic [31:0]      X_TARG;
    logic             FLUSH;
    logic             REDIRECT_VALID;
    logic [31:0]      REDIRECT_PC;
    logic [CNT_W-1:0] MISPRED_CNT;
    logic             ORDER_ERR;

    branch_resolve #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .F_PUSH         (F_PUSH),
        .F_PC           (F_PC),
        .F_PRED_TAKEN   (F_PRED_TAKEN),
        .F_PRED_TARG    (F_PRED_TARG),
        .F_READY        (F_READY),
        .X_RESOLVE      (X_RESOLVE),
        .X_PC           (X_PC),
        .X_TAKEN        (X_TAKEN),
        .X_TARG         (X_TARG),
        .FLUSH          (FLUSH),
        .REDIRECT_VALID (REDIRECT_VALID),
        .REDIRECT_PC    (REDIRECT_PC),
        .MISPRED_CNT    (MISPRED_CNT),
        .ORDER_ERR      (ORDER_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst_n;
        logic        push;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] pg;
        logic        res;
        logic [31:0] xpc;
        logic        xt;
        logic [31:0] xg;
        logic        fl;
        logic        e_rdy;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic [31:0] e_cnt;
        logic        e_oe;
    } vec_t;

    vec_t tv [NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        logic rst_n, logic push, logic [31:0] pc, logic pt,
        logic [31:0] pg, logic res, logic [31:0] xpc, logic xt,
        logic [31:0] xg, logic fl, logic rdy, logic rv,
        logic [31:0] rpc, logic [31:0] cnt, logic oe);
        vec_t v;
        v.rst_n = rst_n; v.push = push; v.pc = pc; v.pt = pt;
        v.pg = pg; v.res = res; v.xpc = xpc; v.xt = xt; v.xg = xg;
        v.fl = fl; v.e_rdy = rdy; v.e_rv = rv; v.e_rpc = rpc;
        v.e_cnt = cnt; v.e_oe = oe;
        return v;
    endfunction

    task automatic chk(string nm, int row, logic [31:0] act,
                       logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    task automatic apply(vec_t v, int row);
        RST_N        = v.rst_n;
        F_PUSH       = v.push;
        F_PC         = v.pc;
        F_PRED_TAKEN = v.pt;
        F_PRED_TARG  = v.pg;
        X_RESOLVE    = v.res;
        X_PC         = v.xpc;
        X_TAKEN      = v.xt;
        X_TARG       = v.xg;
        FLUSH        = v.fl;
        @(posedge CLK);
        #1;
        chk("f_ready", row, 32'(F_READY), 32'(v.e_rdy));
        chk("redirect_valid", row, 32'(REDIRECT_VALID), 32'(v.e_rv));
        chk("mispred_cnt", row, 32'(MISPRED_CNT), v.e_cnt);
        chk("order_err", row, 32'(ORDER_ERR), 32'(v.e_oe));
        if (v.e_rv || !v.rst_n) begin
            chk("redirect_pc", row, REDIRECT_PC, v.e_rpc);
        end
    endtask

    initial begin
        // reset, correct taken prediction
        tv[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tv[1]  = mk(1, 1, 'h100, 1, 'h140, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tv[2]  = mk(1, 0, 0, 0, 0, 1, 'h100, 1, 'h140, 0, 1, 0, 0, 0, 0);
        // predicted not-taken, actually taken
        tv[3]  = mk(1, 1, 'h200, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tv[4]  = mk(1, 0, 0, 0, 0, 1, 'h200, 1, 'h80, 0, 0, 1, 'h80, 1, 0);
        // RDIR cycle: push and resolve both ignored
        tv[5]  = mk(1, 1, 'h999, 0, 0, 1, 'h999, 1, 'h5, 0, 1, 0, 0, 1, 0);
        // predicted taken, actually not-taken
        tv[6]  = mk(1, 1, 'h300, 1, 'h400, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        tv[7]  = mk(1, 0, 0, 0, 0, 1, 'h300, 0, 0, 0, 0, 1, 'h304, 2, 0);
        tv[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0);
        // fall-through PC wraps to zero
        tv[9]  = mk(1, 1, 'hFFFFFFFC, 1, 'h10, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0);
        tv[10] = mk(1, 0, 0, 0, 0, 1, 'hFFFFFFFC, 0, 0, 0, 0, 1, 0, 3, 0);
        tv[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        // fill, overflow drop, pop+push while full, drain in order
        tv[12] = mk(1, 1, 'hA0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        tv[13] = mk(1, 1, 'hA4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        tv[14] = mk(1, 1, 'hA8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        tv[15] = mk(1, 1, 'hAC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        tv[16] = mk(1, 1, 'hB0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        tv[17] = mk(1, 1, 'hC0, 0, 0, 1, 'hA0, 0, 0, 0, 0, 0, 0, 3, 0);
        tv[18] = mk(1, 0, 0, 0, 0, 1, 'hA4, 0, 0, 0, 1, 0, 0, 3, 0);
        tv[19] = mk(1, 0, 0, 0, 0, 1, 'hA8, 0, 0, 0, 1, 0, 0, 3, 0);
        tv[20] = mk(1, 0, 0, 0, 0, 1, 'hAC, 0, 0, 0, 1, 0, 0, 3, 0);
        tv[21] = mk(1, 0, 0, 0, 0, 1, 'hC0, 0, 0, 0, 1, 0, 0, 3, 0);
        // flush beats a mismatching resolve
        tv[22] = mk(1, 1, 'hD0, 1, 'hE0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        tv[23] = mk(1, 1, 'hD4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        tv[24] = mk(1, 0, 0, 0, 0, 1, 'hD0, 0, 0, 1, 1, 0, 0, 3, 0);
        tv[25] = mk(1, 1, 'hF0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        tv[26] = mk(1, 0, 0, 0, 0, 1, 'hF0, 0, 0, 0, 1, 0, 0, 3, 0);
        // resolve on empty queue, sticky error
        tv[27] = mk(1, 0, 0, 0, 0, 1, 'h50, 0, 0, 0, 1, 0, 0, 3, 1);
        tv[28] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 1);

        for (int i = 0; i < NV; i++) begin
            apply(tv[i], i);
        end

        // saturated counter, then reset while in RDIR
        apply(mk(1, 1, 'h100, 1, 'h140, 0, 0, 0, 0, 0,
                 1, 0, 0, 3, 1), 100);
        apply(mk(1, 0, 0, 0, 0, 1, 'h100, 0, 0, 0,
                 0, 1, 'h104, 3, 1), 101);
        apply(mk(0, 1, 'h500, 1, 'h8, 1, 'h100, 0, 0, 0,
                 1, 0, 0, 0, 0), 102);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 0), 103);
        // PC mismatch against head sets the error flag
        apply(mk(1, 1, 'h200, 0, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 0), 104);
        apply(mk(1, 0, 0, 0, 0, 1, 'h204, 0, 0, 0,
                 1, 0, 0, 0, 1), 105);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 1), 106);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
